rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (wr_en/wr_dest/wr_data, sampled by the register file on negedge) between two requesters.
- Requester 1 is the pipeline WB stage: priority, no backpressure.
- Requester 2 is the multi-cycle unit (MCU, multiplier/memory) with valid/ready handshake, buffered in a small FIFO.
- Tracks outstanding MCU destinations in a pending scoreboard for hazard logic, and requests a pipeline bubble when the MCU starves.

Parameters:
- DW, 32, data width.
- AW, 4, register address width (2^AW registers).
- FIFO_DEPTH, 2, MCU result FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 3, consecutive lost cycles before stall_pipe.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- wb_valid  in  1  WB stage write request.
- wb_dest  in  AW  WB destination register.
- wb_data  in  DW  WB result.
- mcu_issue  in  1  MCU op issued this cycle.
- mcu_issue_dest  in  AW  destination of issued MCU op.
- mcu_valid  in  1  MCU result available.
- mcu_ready  out  1  FIFO can accept.
- mcu_dest  in  AW  MCU result destination.
- mcu_data  in  DW  MCU result.
- wr_en  out  1  register file write enable.
- wr_dest  out  AW  register file write address.
- wr_data  out  DW  register file write data.
- wr_src  out  1  0 = WB, 1 = MCU.
- pending  out  2^AW  per-register outstanding-MCU-write bits.
- stall_pipe  out  1  request for a WB bubble.
- fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async): wr_en, wr_dest, wr_data, wr_src = 0; FIFO emptied (contents discarded); fifo_count = 0; pending = 0; wait_cnt = 0; stall_pipe = 0; proto_err = 0. mcu_ready is forced 0 while rst is high. Reset mid-operation loses all queued MCU results.
- mcu_ready = !rst && (fifo_count < FIFO_DEPTH). It depends on count only: when full, a pop does not allow a push in the same cycle.
- Push: at posedge when mcu_valid && mcu_ready, {mcu_dest, mcu_data} is written at the tail. The FIFO has no bypass.
- Grant (combinational, per cycle):
  - wb_valid=1 grants WB.
  - Otherwise FIFO nonempty grants the MCU head (popped at the posedge).
  - Otherwise no grant.
- Output register: at each posedge, wr_en <= granted. When granted, wr_dest/wr_data/wr_src load the winner. When not granted, they hold their previous values.
- Latency: WB is 1 cycle (request at edge k, wr_en high in cycle k..k+1). MCU is a minimum of 2 cycles from handshake edge to wr_en.
- Simultaneous push and pop are allowed when not full; fifo_count is unchanged.
- Starvation:
  - wait_cnt (saturating at STARVE_LIMIT) increments at each posedge where the FIFO is nonempty and no pop occurs.
  - wait_cnt clears on pop or when the FIFO is empty.
  - stall_pipe = (wait_cnt == STARVE_LIMIT), decoded from the register.
  - Contract: the pipeline drives wb_valid=0 while stall_pipe=1. The MCU head then pops and stall_pipe falls at that edge.
  - If wb_valid=1 while stall_pipe=1: WB still wins, the MCU does not pop, proto_err <= 1 (sticky until reset), and stall_pipe stays high.
- Scoreboard:
  - pending[mcu_issue_dest] is set at posedge on mcu_issue.
  - pending[d] is cleared at posedge when an MCU entry with dest d is popped.
  - Set and clear of the same d in the same edge leaves the bit set.
  - WB writes never touch pending.
- A pushed write to dest 15 is forwarded like any other; filtering is the decoder's job.

Test Plan:
- WB only: wb_valid=1, wb_dest=3, wb_data=0x55 for one edge -> next cycle wr_en=1, wr_dest=3, wr_data=0x55, wr_src=0. The following cycle wr_en=0 with wr_dest still 3.
- MCU path: mcu_issue dest 5 -> pending=0x0020. Then handshake mcu_dest=5, data=0xABCD at edge k -> fifo_count=1 after k. At edge k+1: wr_en=1, wr_src=1, wr_data=0xABCD, pending=0x0000.
- Full FIFO (DEPTH=2): wb_valid held 1, push 2 MCU results -> fifo_count=2, mcu_ready=0. A third mcu_valid is held and not accepted; no write is lost.
- Starvation (LIMIT=3): FIFO holds 1 entry, wb_valid=1 for 3 edges -> stall_pipe=1 after 3rd edge. Bench drops wb_valid -> next edge MCU write occurs, stall_pipe=0, proto_err=0.
- Violation: same as previous but wb_valid kept 1 during stall -> WB writes, proto_err=1, stall_pipe stays 1. A subsequent wb_valid=0 pops the MCU entry; proto_err remains 1.
- Async reset mid-op: fifo_count=2, pending=0x0020, rst pulsed between edges -> immediately wr_en=0, fifo_count=0, pending=0, mcu_ready=0. After release, mcu_ready=1 and no stale MCU write appears.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between WB (priority, 1-cycle) and a FIFO-buffered MCU (>=2 cycles).
// The MCU is backpressured through mcu_ready whenever the result FIFO is full; stall_pipe asks WB for a bubble.

module rf_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && (count != FULL);
  assign do_pop   = pop && (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module rf_wb_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_valid,
  input  logic [AW-1:0]               wb_dest,
  input  logic [DW-1:0]               wb_data,
  input  logic                        mcu_issue,
  input  logic [AW-1:0]               mcu_issue_dest,
  input  logic                        mcu_valid,
  output logic                        mcu_ready,
  input  logic [AW-1:0]               mcu_dest,
  input  logic [DW-1:0]               mcu_data,
  output logic                        wr_en,
  output logic [AW-1:0]               wr_dest,
  output logic [DW-1:0]               wr_data,
  output logic                        wr_src,
  output logic [(1<<AW)-1:0]          pending,
  output logic                        stall_pipe,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        proto_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } mcu_ent_t;

  mcu_ent_t              push_ent;
  mcu_ent_t              head_ent;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic [SW-1:0]         wait_cnt;
  logic [(1<<AW)-1:0]    pending_nxt;

  assign mcu_ready  = !rst && (fifo_count < DEPTH_C);
  assign push       = mcu_valid && mcu_ready;
  assign push_ent   = '{dest: mcu_dest, data: mcu_data};
  assign fifo_empty = (fifo_count == '0);
  // WB always wins; the MCU head only drains on cycles WB leaves idle
  assign pop        = !wb_valid && !fifo_empty;
  assign stall_pipe = (wait_cnt == LIMIT_C);

  rf_wb_fifo #(
    .W     ($bits(mcu_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (fifo_count)
  );

  // Issue is applied after the pop clear so a same-edge set keeps the bit high
  always_comb begin
    pending_nxt = pending;
    if (pop)       pending_nxt[head_ent.dest] = 1'b0;
    if (mcu_issue) pending_nxt[mcu_issue_dest] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_dest   <= '0;
      wr_data   <= '0;
      wr_src    <= 1'b0;
      pending   <= '0;
      wait_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      wr_en   <= wb_valid || pop;
      pending <= pending_nxt;
      if (wb_valid) begin
        wr_dest <= wb_dest;
        wr_data <= wb_data;
        wr_src  <= 1'b0;
      end else if (pop) begin
        wr_dest <= head_ent.dest;
        wr_data <= head_ent.data;
        wr_src  <= 1'b1;
      end
      if (fifo_empty || pop)       wait_cnt <= '0;
      else if (wait_cnt != LIMIT_C) wait_cnt <= wait_cnt + 1'b1;
      if (stall_pipe && wb_valid)  proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: queue-based reference model checked every cycle, plus literal checkpoints.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 2;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_dest = '0;
  logic [DW-1:0] wb_data = '0;
  logic          mcu_issue = 1'b0;
  logic [AW-1:0] mcu_issue_dest = '0;
  logic          mcu_valid = 1'b0;
  logic          mcu_ready;
  logic [AW-1:0] mcu_dest = '0;
  logic [DW-1:0] mcu_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_dest;
  logic [DW-1:0] wr_data;
  logic          wr_src;
  logic [15:0]   pending;
  logic          stall_pipe;
  logic [1:0]    fifo_count;
  logic          proto_err;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.DW(DW), .AW(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .mcu_issue(mcu_issue), .mcu_issue_dest(mcu_issue_dest),
    .mcu_valid(mcu_valid), .mcu_ready(mcu_ready), .mcu_dest(mcu_dest), .mcu_data(mcu_data),
    .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data), .wr_src(wr_src),
    .pending(pending), .stall_pipe(stall_pipe), .fifo_count(fifo_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting results and the cycles the head has been passed over
  typedef struct packed {
    logic [AW-1:0] d;
    logic [DW-1:0] v;
  } ent_t;
  ent_t        q[$];
  bit          m_en = 0;
  bit [AW-1:0] m_dest = 0;
  bit [DW-1:0] m_data = 0;
  bit          m_src = 0;
  bit [15:0]   m_pend = 0;
  int          m_wait = 0;
  bit          m_proto = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_en = 0; m_dest = 0; m_data = 0; m_src = 0;
      m_pend = 0; m_wait = 0; m_proto = 0;
    end else begin
      automatic int  sz = q.size();
      automatic bit  popped = 0;
      automatic ent_t h;
      if (wb_valid) begin
        if (m_wait == LIMIT) m_proto = 1;
        m_en = 1; m_dest = wb_dest; m_data = wb_data; m_src = 0;
      end else if (sz > 0) begin
        h = q.pop_front();
        popped = 1;
        m_en = 1; m_dest = h.d; m_data = h.v; m_src = 1;
        m_pend[h.d] = 0;
      end else begin
        m_en = 0;
      end
      if (mcu_issue) m_pend[mcu_issue_dest] = 1;
      if (sz == 0 || popped) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
      if (mcu_valid && sz < DEPTH) q.push_back('{d: mcu_dest, v: mcu_data});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_wr_en", wr_en, m_en);
      chk("m_wr_dest", wr_dest, m_dest);
      chk("m_wr_data", wr_data, m_data);
      chk("m_wr_src", wr_src, m_src);
      chk("m_pending", pending, m_pend);
      chk("m_stall", stall_pipe, m_wait == LIMIT);
      chk("m_count", fifo_count, q.size());
      chk("m_ready", mcu_ready, q.size() < DEPTH);
      chk("m_proto", proto_err, m_proto);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", mcu_ready, 0);
    chk("rst_stall", stall_pipe, 0);
    chk("rst_proto", proto_err, 0);
    tick(); tick();
    rst = 1'b0;
    #1 chk("rel_ready", mcu_ready, 1);

    // WB only
    wb_valid = 1; wb_dest = 3; wb_data = 32'h55;
    tick();
    wb_valid = 0;
    chk("wb_en", wr_en, 1); chk("wb_dest", wr_dest, 3);
    chk("wb_data", wr_data, 32'h55); chk("wb_src", wr_src, 0);
    tick();
    chk("wb_idle_en", wr_en, 0); chk("wb_hold_dest", wr_dest, 3);

    // MCU path
    mcu_issue = 1; mcu_issue_dest = 5;
    tick();
    mcu_issue = 0;
    chk("mcu_pend_set", pending, 16'h0020);
    mcu_valid = 1; mcu_dest = 5; mcu_data = 32'hABCD;
    tick();
    mcu_valid = 0;
    chk("mcu_cnt1", fifo_count, 1); chk("mcu_no_bypass", wr_en, 0);
    tick();
    chk("mcu_en", wr_en, 1); chk("mcu_src", wr_src, 1);
    chk("mcu_data", wr_data, 32'hABCD); chk("mcu_pend_clr", pending, 0);
    chk("mcu_cnt0", fifo_count, 0);

    // Full FIFO while WB holds the port
    wb_valid = 1; wb_dest = 1; wb_data = 32'h11;
    mcu_valid = 1; mcu_dest = 7; mcu_data = 32'h70;
    tick();
    mcu_dest = 8; mcu_data = 32'h71;
    tick();
    chk("full_cnt", fifo_count, 2); chk("full_ready", mcu_ready, 0);
    mcu_dest = 9; mcu_data = 32'h72;
    tick();
    chk("full_hold_cnt", fifo_count, 2); chk("full_wb_src", wr_src, 0);
    wb_valid = 0;
    tick();
    chk("drain0", wr_data, 32'h70); chk("drain0_cnt", fifo_count, 1);
    tick();
    mcu_valid = 0;
    chk("drain1", wr_data, 32'h71); chk("drain1_cnt", fifo_count, 1);
    tick();
    chk("drain2", wr_data, 32'h72); chk("drain2_dest", wr_dest, 9);
    chk("drain2_cnt", fifo_count, 0);

    // Starvation honoured by the pipeline
    wb_valid = 1; wb_dest = 4; wb_data = 32'h44;
    mcu_valid = 1; mcu_dest = 2; mcu_data = 32'h22;
    tick();
    mcu_valid = 0;
    tick(); tick();
    chk("starve_pre", stall_pipe, 0);
    tick();
    chk("starve_on", stall_pipe, 1);
    wb_valid = 0;
    tick();
    chk("starve_pop", wr_data, 32'h22); chk("starve_src", wr_src, 1);
    chk("starve_off", stall_pipe, 0); chk("starve_proto", proto_err, 0);

    // Starvation violated by the pipeline
    wb_valid = 1; wb_data = 32'h88;
    mcu_valid = 1; mcu_dest = 6; mcu_data = 32'h33;
    tick();
    mcu_valid = 0;
    tick(); tick(); tick();
    chk("viol_stall", stall_pipe, 1);
    wb_data = 32'h99;
    tick();
    chk("viol_wb", wr_data, 32'h99); chk("viol_src", wr_src, 0);
    chk("viol_proto", proto_err, 1); chk("viol_stall_hold", stall_pipe, 1);
    chk("viol_cnt", fifo_count, 1);
    wb_valid = 0;
    tick();
    chk("viol_pop", wr_data, 32'h33); chk("viol_pop_src", wr_src, 1);
    chk("viol_sticky", proto_err, 1); chk("viol_stall_off", stall_pipe, 0);

    // Async reset mid-operation
    wb_valid = 1; wb_data = 32'h5A;
    mcu_issue = 1; mcu_issue_dest = 5;
    mcu_valid = 1; mcu_dest = 5; mcu_data = 32'h55AA;
    tick();
    mcu_issue = 0; mcu_data = 32'h55AB;
    tick();
    mcu_valid = 0;
    chk("pre_rst_cnt", fifo_count, 2); chk("pre_rst_pend", pending, 16'h0020);
    rst = 1;
    #1;
    chk("arst_en", wr_en, 0); chk("arst_cnt", fifo_count, 0);
    chk("arst_pend", pending, 0); chk("arst_ready", mcu_ready, 0);
    chk("arst_proto", proto_err, 0);
    wb_valid = 0;
    tick();
    rst = 0;
    #1 chk("post_rst_ready", mcu_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale_en", wr_en, 0);
    end
    chk("no_stale_cnt", fifo_count, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
